// File: rtl/irq_flag_ctrl.sv
// Interrupt flag controller: latches peripheral requests, presents masked pending
// lines to the core, clears acknowledged flags and raises wake while sleeping.
module irq_flag_ctrl #(
  parameter int               N_IRQ     = 23,
  parameter logic [N_IRQ-1:0] EDGE_MASK = 23'h7FFFF,
  parameter int               ACK_HOLD  = 2
) (
  input  logic             cp2,
  input  logic             ireset,
  input  logic [N_IRQ-1:0] src_in,
  input  logic [N_IRQ-1:0] irq_en,
  input  logic [N_IRQ-1:0] sw_clr,
  input  logic             globint,
  input  logic             irqack,
  input  logic [4:0]       irqackad,
  input  logic             sleepi,
  output logic [N_IRQ-1:0] irqlines,
  output logic [N_IRQ-1:0] flags,
  output logic             wake,
  output logic             ack_err
);

  typedef enum logic [0:0] {IDLE = 1'b0, HOLD = 1'b1} state_t;

  localparam logic [5:0] N_IRQ_W   = 6'(N_IRQ);
  localparam logic [3:0] HOLD_LOAD = 4'((ACK_HOLD > 0) ? (ACK_HOLD - 1) : 0);

  state_t           state_r, state_next_s;
  logic [3:0]       hold_cnt_r, hold_cnt_next_s;
  logic [N_IRQ-1:0] src_q_r, flag_r;
  logic             armed_r;
  logic [N_IRQ-1:0] evt_s, clr_s, ack_vec_s, flag_next_s;
  logic             ack_ok_s, ack_err_set_s;

  // Ack address decode: out-of-range addresses decode to nothing
  always_comb begin
    ack_ok_s  = irqack & ({1'b0, irqackad} < N_IRQ_W);
    ack_vec_s = {N_IRQ{1'b0}};
    for (int k = 0; k < N_IRQ; k++) begin
      if (ack_ok_s && (irqackad == 5'(k))) begin
        ack_vec_s[k] = 1'b1;
      end else begin
        ack_vec_s[k] = 1'b0;
      end
    end
  end

  // Flag update; edge detection is disarmed for the first cycle after reset
  always_comb begin
    evt_s         = src_in & ~src_q_r & {N_IRQ{armed_r}};
    clr_s         = ack_vec_s | sw_clr;
    flag_next_s   = (EDGE_MASK & (evt_s | (flag_r & ~clr_s))) | (~EDGE_MASK & src_in);
    ack_err_set_s = (irqack & ~ack_ok_s) | (|(ack_vec_s & EDGE_MASK & ~flag_r));
  end

  // Post-ack hold FSM: an ack in HOLD restarts the hold window
  always_comb begin
    state_next_s    = state_r;
    hold_cnt_next_s = hold_cnt_r;
    case (state_r)
      IDLE: begin
        if (ack_ok_s && (ACK_HOLD > 0)) begin
          state_next_s    = HOLD;
          hold_cnt_next_s = HOLD_LOAD;
        end else begin
          state_next_s    = IDLE;
        end
      end
      HOLD: begin
        if (ack_ok_s) begin
          hold_cnt_next_s = HOLD_LOAD;
        end else if (hold_cnt_r == 4'd0) begin
          state_next_s    = IDLE;
        end else begin
          hold_cnt_next_s = hold_cnt_r - 4'd1;
        end
      end
      default: begin
        state_next_s    = IDLE;
        hold_cnt_next_s = 4'd0;
      end
    endcase
  end

  // State and output registers; lines are blanked for the whole hold window
  always_ff @(posedge cp2) begin
    if (ireset) begin
      state_r    <= IDLE;
      hold_cnt_r <= 4'd0;
      src_q_r    <= {N_IRQ{1'b0}};
      flag_r     <= {N_IRQ{1'b0}};
      armed_r    <= 1'b0;
      irqlines   <= {N_IRQ{1'b0}};
      wake       <= 1'b0;
      ack_err    <= 1'b0;
    end else begin
      state_r    <= state_next_s;
      hold_cnt_r <= hold_cnt_next_s;
      src_q_r    <= src_in;
      flag_r     <= flag_next_s;
      armed_r    <= 1'b1;
      irqlines   <= (state_next_s == IDLE) ? (flag_next_s & irq_en & {N_IRQ{globint}})
                                           : {N_IRQ{1'b0}};
      wake       <= sleepi & (|(flag_next_s & irq_en));
      ack_err    <= ack_err | ack_err_set_s;
    end
  end

  assign flags = flag_r;

endmodule
